// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame width and the even-parity helper.
// Intended to be common to uart_tx and uart_rx.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and asserts tick on the terminal count.
// clear holds the count at zero so the first bit of a frame gets its full length.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = !clear && (cnt == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert the parity bit between the data and stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       tx_data,
  output logic       busy,
  output logic       done
);

  // Handshake: a byte moves on a rising edge where din_valid && din_ready;
  // din_ready is high only in IDLE, and din is captured on that same edge.

  logic [2:0]           state_q, state_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  logic [2:0]           bit_cnt_q, bit_cnt_nxt;
  logic                 stop_cnt_q, stop_cnt_nxt;
  logic                 tick;
  logic                 take;
  logic                 stop_last;
  logic                 tx_nxt, busy_nxt, done_nxt;

`ifdef UART_TX_PARITY_EN
  logic                 par_q;
`endif

  assign din_ready = (state_q == IDLE);
  assign take      = din_valid && din_ready;
  assign stop_last = (stop_cnt_q == 1'(STOP_BITS - 1));

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state_q == IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_data    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      shift_q    <= shift_nxt;
      bit_cnt_q  <= bit_cnt_nxt;
      stop_cnt_q <= stop_cnt_nxt;
      tx_data    <= tx_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is fixed at transfer time so later din changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (take) begin
      par_q <= even_parity(din);
    end
  end
`endif

  always_comb begin
    state_nxt    = state_q;
    shift_nxt    = shift_q;
    bit_cnt_nxt  = bit_cnt_q;
    stop_cnt_nxt = stop_cnt_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_nxt    = START;
          shift_nxt    = din;
          bit_cnt_nxt  = '0;
          stop_cnt_nxt = 1'b0;
        end
      end
      START: begin
        if (tick) state_nxt = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_nxt   = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_cnt_nxt = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (stop_last) state_nxt = IDLE;
          else           stop_cnt_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the upcoming state.
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_q == STOP) && (state_nxt == IDLE);
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_nxt = par_q;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule
